// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO multiply/divide unit for the Execute stage.
// mult/div run for a fixed number of cycles with busy high; the result is
// computed at issue, held internally, and written to HI/LO on the edge busy falls.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_res;
    logic            r_wr;        // cleared for divide-by-zero: HI/LO left untouched
    logic [31:0]     r_hi, r_lo;

    logic            w_md;        // mult/multu/div/divu
    logic            w_last;
    logic signed [32:0] w_a, w_b, w_bd, w_q, w_r;
    logic signed [65:0] w_a66, w_b66, w_prod;
    logic [63:0]     w_res;

    assign w_md   = start && !mdop[2];
    assign w_last = (r_cnt == CW'(1));

    // Operands widened to 33 bits: zero-extend for unsigned ops, sign-extend for
    // signed, so one signed multiplier/divider covers both. 33 bits also keeps
    // 0x80000000 / -1 exact (+2^31) before truncation to 32 bits.
    always_comb begin
        w_a    = mdop[0] ? {1'b0, A} : {A[31], A};
        w_b    = mdop[0] ? {1'b0, B} : {B[31], B};
        w_bd   = (B == 32'd0) ? 33'sd1 : w_b;   // keep the divider defined on B==0
        w_a66  = {{33{w_a[32]}}, w_a};
        w_b66  = {{33{w_b[32]}}, w_b};
        w_prod = w_a66 * w_b66;
        w_q    = w_a / w_bd;
        w_r    = w_a % w_bd;
        w_res  = mdop[1] ? {w_r[31:0], w_q[31:0]} : w_prod[63:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: issue on an MD start in IDLE, return after the last busy cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_md)   w_next = S_BUSY;
            S_BUSY: if (w_last) w_next = S_IDLE;
            default:            w_next = S_IDLE;
        endcase
    end

    // Counter, result latch and HI/LO writes; starts while busy are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_res <= '0;
            r_wr  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                case (mdop)
                    3'b000, 3'b001: begin
                        r_cnt <= MULT_CYCLES[CW-1:0];
                        r_res <= w_res;
                        r_wr  <= 1'b1;
                    end
                    3'b010, 3'b011: begin
                        r_cnt <= DIV_CYCLES[CW-1:0];
                        r_res <= w_res;
                        r_wr  <= (B != 32'd0);
                    end
                    3'b100:  r_hi <= A;
                    3'b101:  r_lo <= A;
                    default: ;
                endcase
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
            if (w_last && r_wr) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: behavioural HI/LO model checked every cycle, plus
// directed literal checks and randomized traffic.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'b0;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_left = 0;      // busy cycles still to run
    bit          m_wr = 1'b0;
    logic [63:0] m_pend = '0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) begin
        longint sa, sb, ua, ub, q, r;
        longint unsigned p;
        if (reset) begin
            m_left = 0; m_wr = 0; m_pend = '0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_wr) {m_hi, m_lo} = m_pend;
        end else if (start) begin
            sa = $signed(A); sb = $signed(B);
            ua = {32'b0, A}; ub = {32'b0, B};
            case (mdop)
                3'd0: begin p = sa * sb; m_pend = p; m_wr = 1; m_left = 5; end
                3'd1: begin p = ua * ub; m_pend = p; m_wr = 1; m_left = 5; end
                3'd2: begin
                    m_left = 10; m_wr = (B != 0);
                    if (B != 0) begin q = sa / sb; r = sa % sb; m_pend = {r[31:0], q[31:0]}; end
                end
                3'd3: begin
                    m_left = 10; m_wr = (B != 0);
                    if (B != 0) begin q = ua / ub; r = ua % ub; m_pend = {r[31:0], q[31:0]}; end
                end
                3'd4: m_hi = A;
                3'd5: m_lo = A;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Single compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {63'b0, busy}, {63'b0, m_left > 0});
            chk("model_hilo", {hi, lo}, {m_hi, m_lo});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mdop = op; A = a; B = b;
        tick();
        start = 1'b0; A = $urandom; B = $urandom;   // operands must be captured at issue only
    endtask

    // Count busy cycles after issue, bounded.
    task automatic wait_idle(input string name, input int exp_n);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin n++; tick(); end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(9, 1));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // 1: reset
        reset = 1'b1; tick(); tick();
        cmp_en = 1'b1;
        reset = 1'b0;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        // 2: mult / multu
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult_busy_len", 5);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu_busy_len", 5);
        chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // 3: div / divu
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_busy_len", 10);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd3, 32'd7, 32'd2);
        wait_idle("divu_busy_len", 10);
        chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

        // 4: mthi then mtlo back to back
        start = 1'b1; mdop = 3'd4; A = 32'h1234_5678;
        tick();
        chk("mthi_hi", {32'b0, hi}, {32'b0, 32'h1234_5678});
        chk("mthi_busy", {63'b0, busy}, 64'd0);
        mdop = 3'd5; A = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        chk("mtlo_lo", {32'b0, lo}, {32'b0, 32'h9ABC_DEF0});
        chk("mtlo_busy", {63'b0, busy}, 64'd0);

        // 5: divide by zero leaves HI/LO, overflow divide
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd3, 32'd1234, 32'd0);
        wait_idle("div0_busy_len", 10);
        chk("div0_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf_busy_len", 10);
        chk("divovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // 6a: reset in busy cycle 3 aborts the mult
        issue(3'd0, 32'd5, 32'd6);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (6) tick();
        chk("abort_no30", {hi, lo}, 64'd0);

        // 6b: start during busy is ignored
        issue(3'd0, 32'd7, 32'd8);
        start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd3;
        tick();
        start = 1'b0;
        wait_idle("ignore_busy_len", 4);
        chk("ignore_hilo", {hi, lo}, 64'd56);

        // randomized traffic, including starts while busy and rare resets
        for (int i = 0; i < 600; i++) begin
            start = ($urandom % 3) == 0;
            mdop  = 3'($urandom % 8);
            A     = pick();
            B     = pick();
            reset = ($urandom % 150) == 0;
            tick();
        end
        start = 1'b0; reset = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
